// File: rtl/platformniossdram_pio_pkg.sv
// rtl/platformniossdram_pio_pkg.sv - shared register map, pulse state and counter width for the output PIO
package platformniossdram_pio_pkg;

  localparam int PLEN_W = 16;

  localparam logic [2:0] ADDR_DATA   = 3'd0;
  localparam logic [2:0] ADDR_PLEN   = 3'd2;
  localparam logic [2:0] ADDR_PULSE  = 3'd3;
  localparam logic [2:0] ADDR_OUTSET = 3'd4;
  localparam logic [2:0] ADDR_OUTCLR = 3'd5;

  typedef enum logic {PS_IDLE, PS_ACTIVE} pulse_state_e;

  // A programmed length of zero still yields a one-cycle pulse.
  function automatic logic [PLEN_W-1:0] plen_eff(input logic [PLEN_W-1:0] plen);
    return (plen == '0) ? PLEN_W'(1) : plen;
  endfunction

endpackage

// File: rtl/platformniossdram_pio_pulse_timer.sv
// rtl/platformniossdram_pio_pulse_timer.sv - one-shot pulse state, countdown and mask; emits set/clear vectors for DATA
module platformniossdram_pio_pulse_timer
  import platformniossdram_pio_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              trig,
  input  logic [WIDTH-1:0]  trig_bits,
  input  logic [PLEN_W-1:0] plen,
  output logic [WIDTH-1:0]  set_vec,
  output logic [WIDTH-1:0]  clr_vec,
  output logic              active,
  output logic [PLEN_W-1:0] count
);

  pulse_state_e      state, state_nxt;
  logic [WIDTH-1:0]  mask, mask_nxt;
  logic [PLEN_W-1:0] count_nxt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= PS_IDLE;
      mask  <= '0;
      count <= '0;
    end else begin
      state <= state_nxt;
      mask  <= mask_nxt;
      count <= count_nxt;
    end
  end

  // A trigger always takes priority, including over expiry in the same cycle.
  always_comb begin
    state_nxt = state;
    mask_nxt  = mask;
    count_nxt = count;
    set_vec   = '0;
    clr_vec   = '0;
    case (state)
      PS_IDLE: begin
        if (trig) begin
          state_nxt = PS_ACTIVE;
          mask_nxt  = trig_bits;
          count_nxt = plen_eff(plen);
          set_vec   = trig_bits;
        end
      end
      PS_ACTIVE: begin
        if (trig) begin
          mask_nxt  = mask | trig_bits;
          count_nxt = plen_eff(plen);
          set_vec   = trig_bits;
        end else if (count == PLEN_W'(1)) begin
          state_nxt = PS_IDLE;
          mask_nxt  = '0;
          count_nxt = '0;
          clr_vec   = mask;
        end else begin
          count_nxt = count - PLEN_W'(1);
        end
      end
      default: state_nxt = PS_IDLE;
    endcase
  end

  assign active = (state == PS_ACTIVE);

endmodule

// File: rtl/platformniossdram_pio_out.sv
// rtl/platformniossdram_pio_out.sv - Avalon-MM output PIO with set/clear and one-shot pulse; PIO_OUT_READBACK_EN enables DATA/PLEN readback
module platformniossdram_pio_out
  import platformniossdram_pio_pkg::*;
#(
  parameter int               WIDTH         = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE   = '0,
  parameter int               DEFAULT_PULSE = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  logic              wr;
  logic [WIDTH-1:0]  wd;
  logic [WIDTH-1:0]  data, data_nxt;
  logic [PLEN_W-1:0] plen;
  logic              trig;
  logic [WIDTH-1:0]  set_vec, clr_vec;
  logic              pulse_active;
  logic [PLEN_W-1:0] pulse_count;
  logic [31:0]       rd_mux;
  logic              unused_wd;

  assign wr        = chipselect & ~write_n;
  assign wd        = writedata[WIDTH-1:0];
  assign trig      = wr && (address == ADDR_PULSE) && (wd != '0);
  assign unused_wd = ^writedata;

  platformniossdram_pio_pulse_timer #(.WIDTH(WIDTH)) u_pulse_timer (
    .clk       (clk),
    .reset_n   (reset_n),
    .trig      (trig),
    .trig_bits (wd),
    .plen      (plen),
    .set_vec   (set_vec),
    .clr_vec   (clr_vec),
    .active    (pulse_active),
    .count     (pulse_count)
  );

  // A DATA write overrides pulse expiry; set/clear compose with it.
  always_comb begin
    data_nxt = (data & ~clr_vec) | set_vec;
    if (wr) begin
      case (address)
        ADDR_DATA:   data_nxt = wd;
        ADDR_OUTSET: data_nxt = data_nxt | wd;
        ADDR_OUTCLR: data_nxt = data_nxt & ~wd;
        default:     ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data <= RESET_VALUE;
      plen <= PLEN_W'(DEFAULT_PULSE);
    end else begin
      data <= data_nxt;
      if (wr && address == ADDR_PLEN) plen <= writedata[PLEN_W-1:0];
    end
  end

  always_comb begin
    rd_mux = '0;
    case (address)
`ifdef PIO_OUT_READBACK_EN
      ADDR_DATA:  rd_mux[WIDTH-1:0]  = data;
      ADDR_PLEN:  rd_mux[PLEN_W-1:0] = plen;
`endif
      ADDR_PULSE: rd_mux = {15'b0, pulse_active, pulse_count};
      default:    ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) readdata <= '0;
    else          readdata <= rd_mux;
  end

  assign out_port = data;

endmodule

// File: tb/tb_platformniossdram_pio_out.sv
// tb/tb_platformniossdram_pio_out.sv - directed self-checking bench for the output PIO
module tb_platformniossdram_pio_out;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [2:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic [7:0]  out_port;

  int checks = 0;
  int errors = 0;

  logic [31:0] rv;

`ifdef PIO_OUT_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  platformniossdram_pio_out #(
    .WIDTH(8),
    .RESET_VALUE(8'hA5),
    .DEFAULT_PULSE(16)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the next negedge, one cycle after the write.
  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b1;
    @(negedge clk);
    chipselect = 1'b0;
    d = readdata;
  endtask

  task automatic idle();
    @(negedge clk);
  endtask

  initial begin
    #3 reset_n = 1'b0;
    #1;
    check("reset_out", out_port, 32'hA5);
    check("reset_rd", readdata, 32'h0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    idle();

    rd(3'd3, rv); check("rst_pulse_status", rv, 32'h0);
    rd(3'd2, rv); check("rst_plen", rv, RB ? 32'h10 : 32'h0);
    rd(3'd1, rv); check("reserved_rd", rv, 32'h0);

    // basic write / set / clear
    wr(3'd0, 32'h3C); check("data_wr", out_port, 32'h3C);
    wr(3'd4, 32'h01); check("outset", out_port, 32'h3D);
    wr(3'd5, 32'h04); check("outclr", out_port, 32'h39);
    rd(3'd0, rv);     check("data_rd", rv, RB ? 32'h39 : 32'h0);
    rd(3'd4, rv);     check("outset_rd", rv, 32'h0);
    wr(3'd1, 32'hFF); check("reserved_wr", out_port, 32'h39);

    // single pulse, PLEN=5
    wr(3'd0, 32'h00);
    wr(3'd2, 32'h5);
    wr(3'd3, 32'h80); check("pulse_c1", out_port, 32'h80);
    rd(3'd3, rv);     check("pulse_status", rv, 32'h10005);
    check("pulse_c2", out_port, 32'h80);
    for (int i = 3; i <= 5; i++) begin
      idle(); check($sformatf("pulse_c%0d", i), out_port, 32'h80);
    end
    idle(); check("pulse_end", out_port, 32'h00);
    rd(3'd3, rv); check("pulse_status_end", rv, 32'h0);

    // retrigger, PLEN=4
    wr(3'd2, 32'h4);
    wr(3'd3, 32'h01); check("retrig_a1", out_port, 32'h01);
    idle();           check("retrig_a2", out_port, 32'h01);
    wr(3'd3, 32'h02); check("retrig_b1", out_port, 32'h03);
    for (int i = 2; i <= 4; i++) begin
      idle(); check($sformatf("retrig_b%0d", i), out_port, 32'h03);
    end
    idle(); check("retrig_end", out_port, 32'h00);

    // expiry conflicts, PLEN=1
    wr(3'd2, 32'h1);
    wr(3'd3, 32'h10); check("exp_data_pulse", out_port, 32'h10);
    wr(3'd0, 32'hFF); check("exp_data_wr", out_port, 32'hFF);
    idle();           check("exp_data_hold", out_port, 32'hFF);
    rd(3'd3, rv);     check("exp_data_status", rv, 32'h0);

    wr(3'd0, 32'h00);
    wr(3'd3, 32'h10);
    wr(3'd4, 32'h01); check("exp_outset", out_port, 32'h01);

    wr(3'd0, 32'h0F);
    wr(3'd3, 32'h10); check("exp_clr_pulse", out_port, 32'h1F);
    wr(3'd5, 32'h01); check("exp_outclr", out_port, 32'h0E);

    wr(3'd0, 32'h00);
    wr(3'd3, 32'h10);
    wr(3'd3, 32'h20); check("exp_retrig", out_port, 32'h30);
    idle();           check("exp_retrig_end", out_port, 32'h00);

    // PLEN=0 and zero trigger
    wr(3'd2, 32'h0);
    wr(3'd3, 32'h02); check("plen0_pulse", out_port, 32'h02);
    idle();           check("plen0_end", out_port, 32'h00);
    wr(3'd0, 32'h55);
    wr(3'd3, 32'h00); check("zero_trig_out", out_port, 32'h55);
    rd(3'd3, rv);     check("zero_trig_status", rv, 32'h0);

    // asynchronous reset mid-pulse
    wr(3'd0, 32'h00);
    wr(3'd2, 32'd20);
    wr(3'd3, 32'h0F); check("rst_pulse_on", out_port, 32'h0F);
    rd(3'd3, rv);     check("rst_pulse_status_on", rv, 32'h10014);
    #2 reset_n = 1'b0;
    #1;
    check("rst_async_out", out_port, 32'hA5);
    check("rst_async_rd", readdata, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    rd(3'd3, rv);     check("rst_status_after", rv, 32'h0);
    rd(3'd2, rv);     check("rst_plen_after", rv, RB ? 32'h10 : 32'h0);
    repeat (4) idle();
    check("rst_out_hold", out_port, 32'hA5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
